// File: rtl/slot_pkg.sv
// Shared types and helpers for the slot-machine reel datapath.
package slot_pkg;

  localparam int unsigned SYM_W           = 4;
  localparam int unsigned DEF_NUM_SYMBOLS = 10;

  typedef enum logic [1:0] {
    IDLE,
    SPIN,
    DECEL,
    STOPPED
  } reel_state_t;

  function automatic logic is_settled(input reel_state_t s);
    return (s == IDLE) || (s == STOPPED);
  endfunction

  // Wrapping symbol increment over 0..n-1.
  function automatic logic [SYM_W-1:0] next_sym(input logic [SYM_W-1:0] cur,
                                                input int unsigned n);
    if (32'(cur) == n - 1) return '0;
    return cur + 1'b1;
  endfunction

endpackage

// File: rtl/reel_spinner_if.sv
// Control/status bundle between the reel controller and its driver.
interface reel_spinner_if;
  import slot_pkg::*;

  logic             start;
  logic             halt;
  logic [SYM_W-1:0] num;
  logic             stop;
  logic             spinning;
  logic             done;

  modport master (output start, halt, input num, stop, spinning, done);
  modport slave  (input start, halt, output num, stop, spinning, done);
endinterface

// File: rtl/tick_divider.sv
// Free-running divider: one-cycle tick every `period` cycles, restart on clr.
module tick_divider #(
  parameter int unsigned CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic [CNT_W:0] period,
  output logic           tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = ({1'b0, cnt_q} == period - 1'b1);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/reel_spinner.sv
// One slot reel: cycles a symbol while spinning, settles on halt.
// Define REEL_DECEL_EN for a stepped slow-down of DECEL_STEPS advances after halt.
module reel_spinner
  import slot_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 10_000_000,
  parameter int unsigned NUM_SYMBOLS = DEF_NUM_SYMBOLS,
  parameter int unsigned START_DIGIT = 0,
  parameter int unsigned DECEL_STEPS = 4
) (
  input logic           clk,
  input logic           rst,
  reel_spinner_if.slave bus
);

  localparam int unsigned MAX_PERIOD = TICK_DIV << DECEL_STEPS;
  localparam int unsigned CNT_W      = (MAX_PERIOD > 1) ? $clog2(MAX_PERIOD) : 1;
  localparam int unsigned PER_W      = CNT_W + 1;

  reel_state_t      state_q, state_d;
  logic [SYM_W-1:0] num_q, num_d;
  logic             stop_q, spinning_q, done_q;
  logic [PER_W-1:0] period;
  logic             tick;
  logic             clr;

`ifdef REEL_DECEL_EN
  localparam int unsigned STEP_W = (DECEL_STEPS > 1) ? $clog2(DECEL_STEPS) : 1;
  logic [STEP_W-1:0] step_q, step_d;

  always_ff @(posedge clk) begin
    if (rst) step_q <= '0;
    else     step_q <= step_d;
  end
`endif

  always_comb begin
    period = PER_W'(TICK_DIV);
`ifdef REEL_DECEL_EN
    // Each deceleration step doubles the dwell time.
    if (state_q == DECEL) period = PER_W'(TICK_DIV) << (32'(step_q) + 32'd1);
`endif
  end

  // Divider runs only while moving and restarts on every state change.
  assign clr = (state_d != state_q) || is_settled(state_q);

  tick_divider #(
    .CNT_W (CNT_W)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .period (period),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
`ifdef REEL_DECEL_EN
    step_d  = step_q;
`endif
    unique case (state_q)
      IDLE, STOPPED: begin
        if (bus.start) state_d = SPIN;
      end
      SPIN: begin
        if (tick) num_d = next_sym(num_q, NUM_SYMBOLS);
        if (bus.halt) begin
`ifdef REEL_DECEL_EN
          state_d = DECEL;
          step_d  = '0;
`else
          state_d = STOPPED;
`endif
        end
      end
      DECEL: begin
`ifdef REEL_DECEL_EN
        if (tick) begin
          num_d  = next_sym(num_q, NUM_SYMBOLS);
          step_d = step_q + 1'b1;
          if (step_q == STEP_W'(DECEL_STEPS - 1)) state_d = STOPPED;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      num_q      <= SYM_W'(START_DIGIT);
      stop_q     <= 1'b1;
      spinning_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      stop_q     <= is_settled(state_d);
      spinning_q <= !is_settled(state_d);
      done_q     <= is_settled(state_d) && !is_settled(state_q);
    end
  end

  assign bus.num      = num_q;
  assign bus.stop     = stop_q;
  assign bus.spinning = spinning_q;
  assign bus.done     = done_q;

endmodule
